// File: rtl/vram_write_buffer.sv
// Write-queue between the Hack CPU screen window and the Screen VRAM port.
// Writes are queued; reads wait until every earlier write has reached VRAM.
module vram_write_buffer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_write,
    input  logic                  cpu_read,
    input  logic [12:0]           cpu_addr,
    input  logic [15:0]           cpu_din,
    output logic                  cpu_stall,
    output logic [15:0]           cpu_dout,
    output logic                  cpu_dout_valid,
    output logic                  vram_load,
    output logic [12:0]           vram_addr,
    output logic [15:0]           vram_din,
    input  logic                  vram_busy,
    input  logic [15:0]           vram_dout,
    output logic [DEPTH_LOG2:0]   fifo_level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_CNT  = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        RD_DRAIN,
        RD_ISSUE,
        RD_CAPTURE,
        RD_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [28:0]            r_fifo [DEPTH];
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2:0]    r_count;
    logic [12:0]            r_rd_addr;
    logic [15:0]            r_dout;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_drain;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_write_ok;
    logic [28:0]            w_head;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_head     = r_fifo[r_rd_ptr];
    assign w_drain    = ((r_state == IDLE) || (r_state == RD_DRAIN)) && !w_empty;
    assign w_pop      = w_drain && !vram_busy;
    // A pending read blocks writes until its RD_DONE cycle, keeping order strict.
    assign w_write_ok = !w_full && (!cpu_read || (r_state == RD_DONE));
    assign w_push     = cpu_write && w_write_ok;

    assign cpu_stall      = (cpu_read && (r_state != RD_DONE)) || (cpu_write && !w_write_ok);
    assign cpu_dout       = r_dout;
    assign cpu_dout_valid = (r_state == RD_DONE);
    assign vram_load      = w_drain;
    assign fifo_level     = r_count;

    always_comb begin
        vram_addr = '0;
        vram_din  = '0;
        if (w_drain) begin
            vram_addr = w_head[28:16];
            vram_din  = w_head[15:0];
        end else if (r_state == RD_ISSUE) begin
            vram_addr = r_rd_addr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (cpu_read) begin
                    if (w_empty || ((r_count == ONE_CNT) && w_pop)) begin
                        w_state_nxt = RD_ISSUE;
                    end else begin
                        w_state_nxt = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (!vram_busy) begin
                    w_state_nxt = RD_CAPTURE;
                end
            end
            RD_CAPTURE: w_state_nxt = RD_DONE;
            RD_DONE:    w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (r_state == RD_CAPTURE) begin
                r_dout <= vram_dout;
            end
        end
    end

    // Queue storage and the latched read address carry no reset; pointers guard them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {cpu_addr, cpu_din};
        end
        if ((r_state == IDLE) && cpu_read) begin
            r_rd_addr <= cpu_addr;
        end
    end
endmodule

// File: tb/tb_vram_write_buffer.sv
// Directed bench for vram_write_buffer with a VRAM model and write/read scoreboards.
module tb_vram_write_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_write = 1'b0;
    logic        cpu_read = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [15:0] cpu_din = '0;
    logic        cpu_stall;
    logic [15:0] cpu_dout;
    logic        cpu_dout_valid;
    logic        vram_load;
    logic [12:0] vram_addr;
    logic [15:0] vram_din;
    logic        vram_busy;
    logic [15:0] vram_dout = '0;
    logic [2:0]  fifo_level;

    logic        busy_set = 1'b0;
    logic        tog_en = 1'b0;
    logic        tog_ph = 1'b0;
    logic [15:0] mem [0:8191];
    logic [28:0] wr_q [$];
    logic [15:0] rd_q [$];
    logic [28:0] mon_w;
    logic [15:0] mon_r;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          stl;

    vram_write_buffer #(.DEPTH_LOG2(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_write(cpu_write), .cpu_read(cpu_read),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_stall(cpu_stall), .cpu_dout(cpu_dout), .cpu_dout_valid(cpu_dout_valid),
        .vram_load(vram_load), .vram_addr(vram_addr), .vram_din(vram_din),
        .vram_busy(vram_busy), .vram_dout(vram_dout), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    assign vram_busy = busy_set | (tog_en & tog_ph);

    always @(posedge clk) begin
        tog_ph <= ~tog_ph;
        if (!vram_busy) begin
            if (vram_load) mem[vram_addr] <= vram_din;
            vram_dout <= mem[vram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed=timeout expected=completion", tag);
    endtask

    always @(negedge clk) begin
        if (!reset && vram_load && !vram_busy) begin
            if (wr_q.size() == 0) begin
                timeout_fail("vram_write_unexpected");
            end else begin
                mon_w = wr_q.pop_front();
                chk("vram_wr_addr", {19'd0, vram_addr}, {19'd0, mon_w[28:16]});
                chk("vram_wr_data", {16'd0, vram_din}, {16'd0, mon_w[15:0]});
            end
        end
        if (!reset && cpu_dout_valid) begin
            if (rd_q.size() == 0) begin
                timeout_fail("read_unexpected");
            end else begin
                mon_r = rd_q.pop_front();
                chk("cpu_dout", {16'd0, cpu_dout}, {16'd0, mon_r});
            end
        end
    end

    task automatic cpu_wr(input logic [12:0] a, input logic [15:0] d, input bit land, output bit stalled);
        bit done = 1'b0;
        stalled = 1'b0;
        cpu_write = 1'b1;
        cpu_addr = a;
        cpu_din = d;
        if (land) wr_q.push_back({a, d});
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1'b1;
            else stalled = 1'b1;
        end
        if (!done) timeout_fail("write_accept");
        @(posedge clk);
        #1 cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [12:0] a, input logic [15:0] e);
        bit done = 1'b0;
        cpu_read = 1'b1;
        cpu_addr = a;
        rd_q.push_back(e);
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1'b1;
        end
        if (done) begin
            chk("rd_valid_at_release", {31'd0, cpu_dout_valid}, 32'd1);
            chk("rd_after_writes_landed", wr_q.size(), 32'd0);
        end else begin
            timeout_fail("read_complete");
        end
        @(posedge clk);
        #1 cpu_read = 1'b0;
        @(negedge clk);
        chk("rd_valid_one_cycle", {31'd0, cpu_dout_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (fifo_level == 3'd0 && !vram_load) done = 1'b1;
        end
        if (!done) timeout_fail("drain");
        chk("drain_all_writes_seen", wr_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed=time limit expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_vram_load", {31'd0, vram_load}, 32'd0);
        chk("rst_vram_addr", {19'd0, vram_addr}, 32'd0);
        chk("rst_vram_din", {16'd0, vram_din}, 32'd0);
        chk("rst_cpu_dout", {16'd0, cpu_dout}, 32'd0);
        chk("rst_dout_valid", {31'd0, cpu_dout_valid}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Burst of four writes into an idle VRAM
        for (int i = 0; i < 4; i++) begin
            cpu_wr(13'(i), 16'hAAAA + 16'(i), 1'b1, stl);
            chk("t1_no_stall", {31'd0, stl}, 32'd0);
        end
        wait_drain();

        // Fill the queue while VRAM is busy, fifth write must stall
        busy_set = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_wr(13'h100 + 13'(i), 16'h5550 + 16'(i), 1'b1, stl);
            chk("t2_fill_no_stall", {31'd0, stl}, 32'd0);
        end
        cpu_write = 1'b1;
        cpu_addr = 13'h104;
        cpu_din = 16'h5554;
        wr_q.push_back({13'h104, 16'h5554});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_full_stall", {31'd0, cpu_stall}, 32'd1);
            chk("t2_full_level", {29'd0, fifo_level}, 32'd4);
        end
        @(posedge clk);
        #1 busy_set = 1'b0;
        begin
            bit done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                @(negedge clk);
                if (!cpu_stall) done = 1'b1;
            end
            if (!done) timeout_fail("t2_fifth_accept");
        end
        @(posedge clk);
        #1 cpu_write = 1'b0;
        wait_drain();

        // Preload VRAM words used by later reads
        cpu_wr(13'h0010, 16'hBEEF, 1'b1, stl);
        cpu_wr(13'h0020, 16'h0007, 1'b1, stl);
        wait_drain();

        // Write then read the top word with VRAM busy toggling
        tog_en = 1'b1;
        cpu_wr(13'h1FFF, 16'h1234, 1'b1, stl);
        cpu_rd(13'h1FFF, 16'h1234);
        tog_en = 1'b0;
        wait_drain();

        // Minimum read latency with empty queue
        cpu_read = 1'b1;
        cpu_addr = 13'h0010;
        rd_q.push_back(16'hBEEF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_stall_early", {31'd0, cpu_stall}, 32'd1);
            chk("t4_valid_early", {31'd0, cpu_dout_valid}, 32'd0);
        end
        @(negedge clk);
        chk("t4_valid_cycle3", {31'd0, cpu_dout_valid}, 32'd1);
        chk("t4_stall_cycle3", {31'd0, cpu_stall}, 32'd0);
        chk("t4_dout_cycle3", {16'd0, cpu_dout}, 32'h0000BEEF);
        @(posedge clk);
        #1 cpu_read = 1'b0;

        // Read-modify-write on one address: read first, write pushed at RD_DONE
        cpu_read = 1'b1;
        cpu_write = 1'b1;
        cpu_addr = 13'h0020;
        cpu_din = 16'h0008;
        rd_q.push_back(16'h0007);
        wr_q.push_back({13'h0020, 16'h0008});
        @(negedge clk);
        chk("t5_stall_start", {31'd0, cpu_stall}, 32'd1);
        begin
            bit done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                @(negedge clk);
                if (!cpu_stall) done = 1'b1;
            end
            if (done) begin
                chk("t5_release_valid", {31'd0, cpu_dout_valid}, 32'd1);
                chk("t5_level_before_push", {29'd0, fifo_level}, 32'd0);
            end else begin
                timeout_fail("t5_release");
            end
        end
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        @(negedge clk);
        chk("t5_write_pushed", {29'd0, fifo_level}, 32'd1);
        @(posedge clk);
        #1;
        wait_drain();
        chk("t5_vram_word", {16'd0, mem[13'h0020]}, 32'h00000008);

        // Reset while a read is issuing and three writes are queued
        busy_set = 1'b1;
        cpu_read = 1'b1;
        cpu_addr = 13'h0030;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_issue_addr", {19'd0, vram_addr}, 32'h00000030);
        chk("t6_issue_noload", {31'd0, vram_load}, 32'd0);
        @(posedge clk);
        #1 cpu_read = 1'b0;
        for (int i = 0; i < 3; i++) cpu_wr(13'h0040 + 13'(i), 16'hDEAD, 1'b0, stl);
        @(negedge clk);
        chk("t6_level_queued", {29'd0, fifo_level}, 32'd3);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        busy_set = 1'b0;
        @(negedge clk);
        chk("t6_level", {29'd0, fifo_level}, 32'd0);
        chk("t6_vram_addr", {19'd0, vram_addr}, 32'd0);
        chk("t6_vram_din", {16'd0, vram_din}, 32'd0);
        chk("t6_cpu_dout", {16'd0, cpu_dout}, 32'd0);
        chk("t6_dout_valid", {31'd0, cpu_dout_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t6_no_vram_load", {31'd0, vram_load}, 32'd0);
            @(negedge clk);
        end

        chk("final_wr_q_empty", wr_q.size(), 32'd0);
        chk("final_rd_q_empty", rd_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
